// File: rtl/fifo_dual_port_if.sv
// rtl/fifo_dual_port_if.sv - push/pop/status bundle for the 2-wide dual-port FIFO
interface fifo_dual_port_if #(
  parameter int DATA_WIDTH = 68,
  parameter int DEPTH      = 32
);
  logic [1:0]              push_cnt;
  logic [DATA_WIDTH-1:0]   din0;
  logic [DATA_WIDTH-1:0]   din1;
  logic [1:0]              push_acc;
  logic [1:0]              pop_cnt;
  logic [1:0]              pop_acc;
  logic [DATA_WIDTH-1:0]   dout0;
  logic [DATA_WIDTH-1:0]   dout1;
  logic                    dout0_valid;
  logic                    dout1_valid;
  logic [$clog2(DEPTH):0]  count;
  logic                    empty;
  logic                    full;
  logic                    almost_full;

  modport master (
    output push_cnt, din0, din1, pop_cnt,
    input  push_acc, pop_acc, dout0, dout1, dout0_valid, dout1_valid,
           count, empty, full, almost_full
  );

  modport slave (
    input  push_cnt, din0, din1, pop_cnt,
    output push_acc, pop_acc, dout0, dout1, dout0_valid, dout1_valid,
           count, empty, full, almost_full
  );
endinterface

// File: rtl/fifo_dual_port.sv
// rtl/fifo_dual_port.sv - dual-push/dual-pop circular queue with wrap-bit pointers
module fifo_dual_port #(
  parameter int DATA_WIDTH = 68,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  fifo_dual_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         occ;
  logic [PW-1:0]         free;
  logic [1:0]            push_acc;
  logic [1:0]            pop_acc;
  logic [AW-1:0]         wr_idx0;
  logic [AW-1:0]         wr_idx1;
  logic [AW-1:0]         rd_idx0;
  logic [AW-1:0]         rd_idx1;

  // Saturate a 0..3 request to 0..2, then clip it to the room available.
  function automatic logic [1:0] trim(input logic [1:0] req, input logic [PW-1:0] room);
    logic [1:0] sat;
    sat = req[1] ? 2'd2 : req;
    if ({{(PW-2){1'b0}}, sat} > room)
      trim = room[1:0];
    else
      trim = sat;
  endfunction

  always_comb begin
    occ      = wr_ptr - rd_ptr;
    free     = DEPTH_P - occ;
    push_acc = (reset || flush) ? 2'd0 : trim(bus.push_cnt, free);
    pop_acc  = (reset || flush) ? 2'd0 : trim(bus.pop_cnt, occ);
    wr_idx0  = wr_ptr[AW-1:0];
    wr_idx1  = wr_idx0 + AW'(1);
    rd_idx0  = rd_ptr[AW-1:0];
    rd_idx1  = rd_idx0 + AW'(1);
  end

  // Storage is never cleared; the valid gating on dout hides stale entries.
  always_ff @(posedge clk) begin
    if (push_acc != 2'd0)
      mem[wr_idx0] <= bus.din0;
    if (push_acc == 2'd2)
      mem[wr_idx1] <= bus.din1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr + {{(PW-2){1'b0}}, pop_acc};
      wr_ptr <= wr_ptr + {{(PW-2){1'b0}}, push_acc};
    end
  end

  assign bus.push_acc    = push_acc;
  assign bus.pop_acc     = pop_acc;
  assign bus.count       = occ;
  assign bus.empty       = (occ == '0);
  assign bus.full        = (occ == DEPTH_P);
  assign bus.almost_full = (occ >= AF_P);
  assign bus.dout0_valid = (occ != '0);
  assign bus.dout1_valid = (occ > PW'(1));
  assign bus.dout0       = (occ != '0)    ? mem[rd_idx0] : '0;
  assign bus.dout1       = (occ > PW'(1)) ? mem[rd_idx1] : '0;
endmodule

// File: tb/tb_fifo_dual_port.sv
// tb/tb_fifo_dual_port.sv - randomized and directed check of fifo_dual_port against a queue model
module tb_fifo_dual_port;
  localparam int DW    = 68;
  localparam int DEPTH = 32;
  localparam int AF    = 30;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  fifo_dual_port_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_dual_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One cycle: drive, check everything against the model, clock, update the model.
  task automatic step(input logic [1:0] pc, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [1:0] oc, input logic fl, input logic rs);
    int sz, pr, orq, ep, eo;
    reset        = rs;
    flush        = fl;
    bus.push_cnt = pc;
    bus.din0     = d0;
    bus.din1     = d1;
    bus.pop_cnt  = oc;
    #1;
    sz  = q.size();
    pr  = (pc == 2'd3) ? 2 : int'(pc);
    orq = (oc == 2'd3) ? 2 : int'(oc);
    ep  = (rs || fl) ? 0 : ((pr < DEPTH - sz) ? pr : DEPTH - sz);
    eo  = (rs || fl) ? 0 : ((orq < sz) ? orq : sz);
    chk("count",       DW'(bus.count),       DW'(sz));
    chk("empty",       DW'(bus.empty),       DW'(sz == 0));
    chk("full",        DW'(bus.full),        DW'(sz == DEPTH));
    chk("almost_full", DW'(bus.almost_full), DW'(sz >= AF));
    chk("dout0_valid", DW'(bus.dout0_valid), DW'(sz >= 1));
    chk("dout1_valid", DW'(bus.dout1_valid), DW'(sz >= 2));
    chk("dout0",       bus.dout0,            (sz >= 1) ? q[0] : '0);
    chk("dout1",       bus.dout1,            (sz >= 2) ? q[1] : '0);
    chk("push_acc",    DW'(bus.push_acc),    DW'(ep));
    chk("pop_acc",     DW'(bus.pop_acc),     DW'(eo));
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      repeat (eo) void'(q.pop_front());
      if (ep >= 1) q.push_back(d0);
      if (ep == 2) q.push_back(d1);
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    bus.push_cnt = 2'd2;
    bus.din0     = '0;
    bus.din1     = '0;
    bus.pop_cnt  = 2'd2;
    #1;
    chk("reset_push_acc", DW'(bus.push_acc), '0);
    chk("reset_pop_acc",  DW'(bus.pop_acc),  '0);
    @(posedge clk);
    q.delete();
    @(negedge clk);

    // First push of two, then observe both on the head pair.
    step(2'd2, DW'(68'hA), DW'(68'hB), 2'd0, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd0, 1'b0, 1'b0);

    // Fill from empty, overflow attempt, trim to one at count 31, push2/pop2 at full.
    step(2'd0, '0, '0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      step(2'd2, DW'(100 + 2 * i), DW'(101 + 2 * i), 2'd0, 1'b0, 1'b0);
    step(2'd2, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd1, 1'b0, 1'b0);
    step(2'd2, DW'(68'h1), DW'(68'h2), 2'd0, 1'b0, 1'b0);
    step(2'd2, rnd(), rnd(), 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step(2'd0, '0, '0, 2'd2, 1'b0, 1'b0);

    // Single entry popped by a pop of two, then pop on empty.
    step(2'd1, DW'(68'h5), '0, 2'd0, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd2, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd1, 1'b0, 1'b0);

    // push2/pop2 with a single entry stored.
    step(2'd1, DW'(68'h7), '0, 2'd0, 1'b0, 1'b0);
    step(2'd2, DW'(68'h8), DW'(68'h9), 2'd2, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd3, 1'b0, 1'b0);

    // Head pair straddling index 31/0.
    step(2'd0, '0, '0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++)
      step(2'd2, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      step(2'd0, '0, '0, 2'd2, 1'b0, 1'b0);
    step(2'd2, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    step(2'd2, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd1, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd0, 1'b0, 1'b0);
    step(2'd0, '0, '0, 2'd3, 1'b0, 1'b0);

    // Random streaming across several wraps.
    for (int i = 0; i < 100; i++)
      step(2'($urandom_range(0, 3)), rnd(), rnd(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(2'd3, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++)
      step(2'($urandom_range(0, 3)), rnd(), rnd(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);

    // Flush and then reset mid-stream with concurrent push/pop requests.
    step(2'd0, '0, '0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(2'd2, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    step(2'd2, rnd(), rnd(), 2'd2, 1'b1, 1'b0);
    step(2'd0, '0, '0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(2'd2, rnd(), rnd(), 2'd0, 1'b0, 1'b0);
    step(2'd2, rnd(), rnd(), 2'd2, 1'b1, 1'b1);
    step(2'd0, '0, '0, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_dual_port.md
# fifo_dual_port

Dual-push / dual-pop circular queue, the 2-wide successor to the single-entry FIFO used between fetch and decode. Accepts up to two entries and retires up to two entries per cycle, uses all DEPTH slots (wrap-bit pointers), and provides occupancy count, almost-full, accepted-count feedback and a synchronous flush for branch/exception redirect. It sits between the instruction-fetch stage and a dual-issue decode stage, and can be reused as a generic 2-wide buffer.

## Interface
- DATA_WIDTH, 68, width of one entry
- DEPTH, 32, number of entries; power of two, >= 4
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; 1..DEPTH

- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; one clock; clears queue
- flush  input  1  synchronous clear of queue contents, same effect as reset on pointers
- push_cnt  input  2  entries requested to push this cycle (0,1,2; 3 treated as 2)
- din0  input  DATA_WIDTH  first (older) entry to push
- din1  input  DATA_WIDTH  second (younger) entry; used only when push_cnt >= 2
- push_acc  output  2  entries actually accepted this cycle (combinational)
- pop_cnt  input  2  entries requested to pop this cycle (0,1,2; 3 treated as 2)
- pop_acc  output  2  entries actually popped this cycle (combinational)
- dout0  output  DATA_WIDTH  oldest entry (head); 0 when dout0_valid=0
- dout1  output  DATA_WIDTH  second-oldest entry; 0 when dout1_valid=0
- dout0_valid  output  1  count >= 1
- dout1_valid  output  1  count >= 2
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AF_LEVEL

## Operation
- Pointers rd_ptr, wr_ptr are $clog2(DEPTH)+1 bits; low bits index storage, MSB is wrap bit. count = wr_ptr - rd_ptr (modulo 2^(log2 DEPTH+1)); full when indices equal and wrap bits differ.
- First-word-fall-through: dout0 = mem[rd_ptr], dout1 = mem[rd_ptr+1] (index wraps modulo DEPTH), combinational from registered state.
- free = DEPTH - count, sampled at start of cycle; same-cycle pops do NOT create push space.
- push_acc = min(sat(push_cnt), free). din0 written at wr_ptr, din1 at wr_ptr+1 (wraps). If push_acc = 1 with push_cnt = 2, only din0 is written; the producer retries din1.
- pop_acc = min(sat(pop_cnt), count). Entries pushed this cycle are not poppable this cycle.
- Next state: rd_ptr += pop_acc, wr_ptr += push_acc.
- flush=1: next rd_ptr = wr_ptr = 0; push_acc and pop_acc forced to 0 that cycle; storage contents don't care.
- reset has priority over flush; both clear pointers; storage need not be cleared, since dout gating hides stale data.
- Overflow and underflow are impossible by construction; requests beyond capacity are silently trimmed, and push_acc/pop_acc report what happened.

## Timing
- Reset values (cycle after reset high): count=0, empty=1, full=0, almost_full=0 (unless AF_LEVEL... AF_LEVEL>=1 so 0), dout0_valid=dout1_valid=0, dout0=dout1=0, push_acc=pop_acc=0 while reset high.
- Write-to-read latency 1 cycle: entry pushed at edge N is on dout at N+1; no empty bypass.
- count, empty, full, almost_full, dout* update 1 cycle after the accepting edge; push_acc/pop_acc are same-cycle combinational, with no input-to-output path other than push_cnt->push_acc and pop_cnt->pop_acc.
- Simultaneous push 2 / pop 2 at full: pop_acc=2, push_acc=0; next count = DEPTH-2.
- Simultaneous push 2 / pop 2 at count 1: pop_acc=1, push_acc=2; next count = 2.
- Pointer wrap: consecutive indices DEPTH-1 and 0 are valid head pair; dout1 reads index 0.
- Reset or flush asserted mid-stream: cycle after, queue empty, regardless of concurrent push/pop.

## Test plan
- Reset, then push_cnt=2 with din0=0xA, din1=0xB -> push_acc=2; next cycle count=2, dout0=0xA, dout1=0xB, both valid.
- Fill with 16 cycles of push 2 (DEPTH=32) -> full=1, count=32, almost_full from count 30; further push_cnt=2 -> push_acc=0, contents unchanged.
- count=31, push_cnt=2 din0=0x1 din1=0x2 -> push_acc=1; tail holds 0x1, full next cycle, 0x2 never stored.
- Count=1 (head 0x5), pop_cnt=2 -> pop_acc=1, empty next cycle, dout0=0, dout0_valid=0; pop on empty -> pop_acc=0.
- Stream 100 cycles of random push/pop 0..2 against a reference queue -> dout order, count and acc values match every cycle across multiple wraps, including head pair straddling index 31/0.
- Queue holding 10 entries, flush with push_cnt=2 and pop_cnt=2 -> push_acc=pop_acc=0, next cycle count=0, empty=1; repeat with reset -> same.
